// File: rtl/double_pkg.sv
// Shared definitions for the double-precision tap delay line: data width,
// the +0.0 constant and the delay-line state encoding.
package double_pkg;

    localparam int          DOUBLE_W        = 64;
    localparam logic [63:0] DOUBLE_POS_ZERO = 64'h0000_0000_0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_TAIL   = 2'd2,
        ST_COMMIT = 2'd3
    } dl_state_t;

endpackage

// File: rtl/double_tap_ram.sv
// Simple dual-port tap storage: one write port, one read port with a
// registered output. Array contents are intentionally left unreset.
module double_tap_ram
    import double_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk_operation,
    input  logic                rst,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [DOUBLE_W-1:0] wdata,
    input  logic                re,
    input  logic [AW-1:0]       raddr,
    output logic [DOUBLE_W-1:0] rdata
);

    logic [DOUBLE_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_operation) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/double_tap_delay_line.sv
// Circular history of DEPTH double samples, streamed newest-to-oldest on request.
// Optional build macro DELAY_ZERO_FILL_EN replaces never-written taps with +0.0.
//
// state  | meaning
// IDLE   | samples written directly; scan_start accepted
// SCAN   | one RAM read per cycle at (base - k), k = 0..DEPTH-1
// TAIL   | last tap presented from the RAM read register
// COMMIT | sample held back during the scan is written, then back to IDLE
module double_tap_delay_line
    import double_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                clk_operation,
    input  logic                rst,
    input  logic [DOUBLE_W-1:0] double_in,
    input  logic                ready,
    input  logic                scan_start,
    output logic [DOUBLE_W-1:0] tap_out,
    output logic                tap_valid,
    output logic [AW-1:0]       tap_idx,
    output logic                tap_last,
    output logic                busy,
    output logic                full,
    output logic                overrun
);

    dl_state_t           state, state_nx;
    logic [AW-1:0]       wp, base, k, raddr;
    logic [AW:0]         fill;
    logic [DOUBLE_W-1:0] pend, wdata, rdata;
    logic                pend_vld, we, scan_rd, in_idle, in_commit;

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (scan_start) state_nx = ST_SCAN;
            ST_SCAN:   if (k == AW'(DEPTH - 1)) state_nx = ST_TAIL;
            ST_TAIL:   state_nx = ST_COMMIT;
            ST_COMMIT: state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // A ready arriving in COMMIT is newer than the pending sample, so it is the one committed.
    always_comb begin
        busy      = (state != ST_IDLE);
        in_idle   = (state == ST_IDLE);
        in_commit = (state == ST_COMMIT);
        scan_rd   = (state == ST_SCAN);
        we        = 1'b0;
        wdata     = double_in;
        if (in_idle) begin
            we = ready;
        end else if (in_commit) begin
            we    = ready | pend_vld;
            wdata = ready ? double_in : pend;
        end
    end

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            wp   <= '0;
            fill <= '0;
        end else if (we) begin
            wp <= wp + AW'(1);
            if (fill != (AW+1)'(DEPTH)) begin
                fill <= fill + (AW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            base <= '0;
            k    <= '0;
        end else if (in_idle && scan_start) begin
            base <= ready ? wp : wp - AW'(1);
            k    <= '0;
        end else if (scan_rd) begin
            k <= k + AW'(1);
        end
    end

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            pend     <= '0;
            pend_vld <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            overrun <= busy && ready && pend_vld;
            if (in_commit) begin
                pend_vld <= 1'b0;
            end else if (busy && ready) begin
                pend     <= double_in;
                pend_vld <= 1'b1;
            end
        end
    end

    assign raddr = base - k;

    double_tap_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk_operation (clk_operation),
        .rst           (rst),
        .we            (we),
        .waddr         (wp),
        .wdata         (wdata),
        .re            (scan_rd),
        .raddr         (raddr),
        .rdata         (rdata)
    );

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            tap_valid <= 1'b0;
            tap_idx   <= '0;
            tap_last  <= 1'b0;
        end else begin
            tap_valid <= scan_rd;
            tap_idx   <= scan_rd ? k : '0;
            tap_last  <= scan_rd && (k == AW'(DEPTH - 1));
        end
    end

`ifdef DELAY_ZERO_FILL_EN
    logic zero_tap;

    always_ff @(posedge clk_operation or negedge rst) begin
        if (!rst) begin
            zero_tap <= 1'b0;
        end else begin
            zero_tap <= scan_rd && ({1'b0, k} >= fill);
        end
    end

    assign tap_out = (tap_valid && !zero_tap) ? rdata : DOUBLE_POS_ZERO;
`else
    assign tap_out = tap_valid ? rdata : DOUBLE_POS_ZERO;
`endif

    assign full = (fill == (AW+1)'(DEPTH));

endmodule
